// File: rtl/seg_anim_player.sv
// seg_anim_player: multi-digit 7-segment animation player.
// Steps a frame range (once/loop/ping-pong) and scans it onto the display.
module seg_anim_player #(
  parameter int NUM_DIGITS = 4,
  parameter int FRAME_BITS = 5,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [1:0]            mode,
  input  logic [FRAME_BITS-1:0] first_frame,
  input  logic [FRAME_BITS-1:0] last_frame,
  input  logic                  wr_en,
  input  logic [FRAME_BITS-1:0] wr_frame,
  input  logic [DW-1:0]         wr_digit,
  input  logic [6:0]            wr_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  done
);

  localparam int NF = 1 << FRAME_BITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] first_q, first_d;
  logic [FRAME_BITS-1:0] last_q, last_d;
  logic [1:0]            mode_q, mode_d;
  logic                  dn_q, dn_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  done_q, done_d;
  logic                  term;
  logic                  wr_ok;

  logic [6:0] mem_q [NF][NUM_DIGITS];

  assign wr_ok = ({1'b0, wr_digit} < (DW+1)'(NUM_DIGITS));
  assign term  = (tick_q == TW'(TICK_DIV - 1));

  // Pattern memory: plain synchronous write, never reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem_q[wr_frame][wr_digit] <= wr_data;
  end

  // Playback control: stop > start > frame stepping.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    first_d = first_q;
    last_d  = last_q;
    mode_d  = mode_q;
    dn_d    = dn_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start && (first_frame <= last_frame)) begin
      state_d = RUN;
      first_d = first_frame;
      last_d  = last_frame;
      mode_d  = mode;
      frame_d = first_frame;
      tick_d  = '0;
      dn_d    = 1'b0;
    end else if (state_q == RUN || state_q == PAUSE) begin
      state_d = pause ? PAUSE : RUN;
      // A terminal count that coincides with the pause rise still advances.
      if (!pause || (state_q == RUN && term)) begin
        if (!term) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          unique case (1'b1)
            mode_q == 2'b00: begin
              if (frame_q < last_q) begin
                frame_d = frame_q + 1'b1;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
            mode_q == 2'b10: begin
              if (!dn_q) begin
                if (frame_q < last_q) begin
                  frame_d = frame_q + 1'b1;
                end else begin
                  dn_d = 1'b1;
                  if (frame_q > first_q) frame_d = frame_q - 1'b1;
                end
              end else begin
                if (frame_q > first_q) begin
                  frame_d = frame_q - 1'b1;
                end else begin
                  dn_d = 1'b0;
                  if (frame_q < last_q) frame_d = frame_q + 1'b1;
                end
              end
            end
            default: begin
              frame_d = (frame_q < last_q) ? frame_q + 1'b1 : first_q;
            end
          endcase
        end
      end
    end
  end

  // Digit scan and registered readout; blank and parked in IDLE.
  always_comb begin
    scnt_d = scnt_q;
    dig_d  = dig_q;
    seg_d  = 7'h7F;
    an_d   = '1;
    if (state_q == IDLE) begin
      scnt_d = '0;
      dig_d  = '0;
    end else begin
      seg_d = mem_q[frame_q][dig_q];
      an_d  = ~(NUM_DIGITS'(1) << dig_q);
      if (scnt_q == SW'(SCAN_DIV - 1)) begin
        scnt_d = '0;
        dig_d  = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      first_q <= '0;
      last_q  <= '0;
      mode_q  <= '0;
      dn_q    <= 1'b0;
      tick_q  <= '0;
      scnt_q  <= '0;
      dig_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      first_q <= first_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      dn_q    <= dn_d;
      tick_q  <= tick_d;
      scnt_q  <= scnt_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      done_q  <= done_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;

endmodule

// File: tb/tb_seg_anim_player.sv
// tb_seg_anim_player: scoreboard bench for seg_anim_player.
// Small parameters: 2 digits, 8 frames, 4-clock hold, 2-clock scan.
module tb_seg_anim_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] first_frame = '0;
  logic [2:0] last_frame = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_frame = '0;
  logic [0:0] wr_digit = '0;
  logic [6:0] wr_data = '0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [2:0] frame;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] frame;
    logic [1:0] an;
    logic [6:0] seg;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] fcyc[$];
  logic [6:0] exp_mem [8][2];

  seg_anim_player #(
    .NUM_DIGITS(2),
    .FRAME_BITS(3),
    .TICK_DIV(4),
    .SCAN_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .mode(mode),
    .first_frame(first_frame),
    .last_frame(last_frame),
    .wr_en(wr_en),
    .wr_frame(wr_frame),
    .wr_digit(wr_digit),
    .wr_data(wr_data),
    .seg(seg),
    .an(an),
    .frame(frame),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic hold(input logic [2:0] f, input int n);
    repeat (n) fcyc.push_back(f);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_an"}, an, 2'b11);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Push one expectation per cycle from fcyc, then start and drain.
  task automatic play(input string tag, input logic [1:0] m,
                      input logic [2:0] f, input logic [2:0] l,
                      input int done_at, input int busy_n,
                      input int pon, input int poff,
                      input int wk, input logic [6:0] wv);
    exp_t e;
    int d;
    int n;
    sb.delete();
    for (int k = 0; k < fcyc.size(); k++) begin
      e.frame = fcyc[k];
      e.busy  = (k < busy_n);
      e.done  = (k == done_at);
      if (k == 0) begin
        e.an  = 2'b11;
        e.seg = 7'h7F;
      end else begin
        d     = ((k - 1) / 2) % 2;
        e.an  = (d != 0) ? 2'b01 : 2'b10;
        e.seg = exp_mem[fcyc[k-1]][d];
        if (wk >= 0 && k >= wk + 2 && fcyc[k-1] == 3'd6 && d == 0)
          e.seg = wv;
      end
      sb.push_back(e);
    end
    n = sb.size();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b1;
    mode = m;
    first_frame = f;
    last_frame = l;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      check({tag, "_frame"}, frame, e.frame);
      check({tag, "_an"}, an, e.an);
      check({tag, "_seg"}, seg, e.seg);
      check({tag, "_busy"}, busy, e.busy);
      check({tag, "_done"}, done, e.done);
      if (k == pon) pause = 1'b1;
      if (k == poff) pause = 1'b0;
      if (k == wk) begin
        wr_en = 1'b1;
        wr_frame = 3'd6;
        wr_digit = 1'b0;
        wr_data = wv;
      end
      if (k == wk + 1) wr_en = 1'b0;
      if (k != n - 1) @(negedge clk);
    end
    pause = 1'b0;
    wr_en = 1'b0;
    if (wk >= 0) exp_mem[6][0] = wv;
  endtask

  initial begin
    for (int f = 0; f < 8; f++)
      for (int d = 0; d < 2; d++)
        exp_mem[f][d] = {3'(f), 1'(d), 3'b101};

    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_frame", frame, 3'd0);
    rst = 1'b0;

    for (int f = 0; f < 8; f++)
      for (int d = 0; d < 2; d++) begin
        @(negedge clk);
        wr_en = 1'b1;
        wr_frame = 3'(f);
        wr_digit = 1'(d);
        wr_data = exp_mem[f][d];
      end
    @(negedge clk);
    wr_en = 1'b0;
    check_idle("idle");

    fcyc.delete();
    hold(3'd2, 4); hold(3'd3, 4); hold(3'd4, 12);
    play("once", 2'b00, 3'd2, 3'd4, 12, 12, -1, -1, -1, 7'h00);

    fcyc.delete();
    hold(3'd5, 4); hold(3'd6, 4); hold(3'd7, 4);
    hold(3'd5, 4); hold(3'd6, 4);
    play("loop", 2'b01, 3'd5, 3'd7, -1, 99, -1, -1, -1, 7'h00);

    fcyc.delete();
    hold(3'd1, 4); hold(3'd2, 4); hold(3'd3, 4); hold(3'd2, 4);
    hold(3'd1, 4); hold(3'd2, 4); hold(3'd3, 4);
    play("pp", 2'b10, 3'd1, 3'd3, -1, 99, -1, -1, -1, 7'h00);

    fcyc.delete();
    hold(3'd6, 16);
    play("pp1", 2'b10, 3'd6, 3'd6, -1, 99, -1, -1, 5, 7'h2A);

    fcyc.delete();
    hold(3'd0, 14); hold(3'd1, 4); hold(3'd0, 2);
    play("pause", 2'b01, 3'd0, 3'd1, -1, 99, 1, 11, -1, 7'h00);

    fcyc.delete();
    hold(3'd1, 4); hold(3'd2, 4);
    play("mode3", 2'b11, 3'd1, 3'd2, -1, 99, -1, -1, -1, 7'h00);

    // Inverted range is ignored from IDLE.
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b1;
    first_frame = 3'd5;
    last_frame = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check_idle("badrange");
      @(negedge clk);
    end

    // start together with stop while running.
    start = 1'b1;
    mode = 2'b01;
    first_frame = 3'd0;
    last_frame = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ss_run_busy", busy, 1'b1);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check_idle("ss");

    // Asynchronous reset mid-run.
    start = 1'b1;
    mode = 2'b01;
    first_frame = 3'd3;
    last_frame = 3'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("arst_pre_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("arst");
    check("arst_frame", frame, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_idle("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
